// File: rtl/food_spawner.sv
`timescale 1ns/1ps
// food_spawner: draws random X/Y candidates from the PRNG, rejects cells that
// are off the playfield or occupied by the snake, and reports a food cell.
// Optional feature macro: FOOD_SCAN_FALLBACK_EN. When defined, exhausting
// MAX_TRIES random attempts starts a linear sweep of the playfield. When it is
// not defined, exhaustion reports fail immediately.
//
// Handshakes:
//   place_req is a one-cycle request and is accepted only in IDLE.
//   rnd is consumed on every rising edge where rnd_step=1.
//   occ_req is a valid signal that stays high until occ_ack is seen, with
//   occ_x/occ_y held stable. occ_ack may arrive in the first occ_req cycle.
//   occ_req is low in the cycle after the ack.
//   done/fail are one-cycle pulses. busy covers the whole operation.
module food_spawner #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int COORD_W   = 6,
    parameter int MAX_TRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               place_req,
    input  logic [COORD_W-1:0] rnd,
    output logic               rnd_step,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               done,
    output logic               fail,
    output logic               busy,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_X = 3'd1,
        GET_Y = 3'd2,
        CHECK = 3'd3,
        QUERY = 3'd4,
        DONE  = 3'd5,
        FAIL  = 3'd6
`ifdef FOOD_SCAN_FALLBACK_EN
        , SCAN = 3'd7
`endif
    } state_t;

    // Limits widened by one bit so that a grid of exactly 2^COORD_W cells works.
    localparam logic [COORD_W:0] X_LIM   = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0] Y_LIM   = (COORD_W+1)'(GRID_H);
    localparam logic [7:0]       TRY_LIM = 8'(MAX_TRIES);
`ifdef FOOD_SCAN_FALLBACK_EN
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
`endif

    state_t             state, state_n;
    logic [COORD_W-1:0] cand_x, cand_x_n;
    logic [COORD_W-1:0] cand_y, cand_y_n;
    logic [7:0]         tries, tries_n;
    logic [7:0]         tries_inc;
    logic               out_of_range;
    logic               reject;
    logic               food_ld;
`ifdef FOOD_SCAN_FALLBACK_EN
    logic               scan, scan_n;
    logic               last_cell;
`endif

    // The try counter saturates so that it can never wrap back below the limit.
    assign tries_inc    = (tries == 8'hFF) ? tries : tries + 8'd1;
    assign out_of_range = ({1'b0, cand_x} >= X_LIM) || ({1'b0, cand_y} >= Y_LIM);
`ifdef FOOD_SCAN_FALLBACK_EN
    assign last_cell    = (cand_x == X_MAX) && (cand_y == Y_MAX);
`endif

    // Outputs are decoded from the state, so they all fall to 0 with reset.
    assign rnd_step  = (state == GET_X) || (state == GET_Y);
    assign occ_req   = (state == QUERY);
    assign occ_x     = cand_x;
    assign occ_y     = cand_y;
    assign done      = (state == DONE);
    assign fail      = (state == FAIL);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Next-state and datapath decisions. A rejected candidate is handled in one place.
    always_comb begin
        state_n  = state;
        cand_x_n = cand_x;
        cand_y_n = cand_y;
        tries_n  = tries;
        reject   = 1'b0;
        food_ld  = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        scan_n   = scan;
`endif
        case (state)
            IDLE: begin
                if (place_req) begin
                    state_n = GET_X;
                    tries_n = 8'd0;
`ifdef FOOD_SCAN_FALLBACK_EN
                    scan_n  = 1'b0;
`endif
                end
            end
            GET_X: begin
                cand_x_n = rnd;
                state_n  = GET_Y;
            end
            GET_Y: begin
                cand_y_n = rnd;
                state_n  = CHECK;
            end
            CHECK: begin
                if (out_of_range) begin
                    reject = 1'b1;
                end else begin
                    state_n = QUERY;
                end
            end
            QUERY: begin
                if (occ_ack) begin
                    if (!occ_hit) begin
                        food_ld = 1'b1;
                        state_n = DONE;
                    end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
                        if (scan) begin
                            if (last_cell) begin
                                state_n = FAIL;
                            end else begin
                                state_n = SCAN;
                                if (cand_x == X_MAX) begin
                                    cand_x_n = '0;
                                    cand_y_n = cand_y + 1'b1;
                                end else begin
                                    cand_x_n = cand_x + 1'b1;
                                end
                            end
                        end else begin
                            reject = 1'b1;
                        end
`else
                        reject = 1'b1;
`endif
                    end
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            SCAN: begin
                // The idle cycle here keeps occ_req low between two sweep queries.
                state_n = QUERY;
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            FAIL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (reject) begin
            tries_n = tries_inc;
            if (tries_inc == TRY_LIM) begin
`ifdef FOOD_SCAN_FALLBACK_EN
                state_n  = SCAN;
                scan_n   = 1'b1;
                cand_x_n = '0;
                cand_y_n = '0;
`else
                state_n  = FAIL;
`endif
            end else begin
                state_n = GET_X;
            end
        end
    end

    // State, candidate, try counter and food registers. An async reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cand_x <= '0;
            cand_y <= '0;
            tries  <= 8'd0;
            food_x <= '0;
            food_y <= '0;
        end else begin
            state  <= state_n;
            cand_x <= cand_x_n;
            cand_y <= cand_y_n;
            tries  <= tries_n;
            if (food_ld) begin
                food_x <= cand_x;
                food_y <= cand_y;
            end
        end
    end

`ifdef FOOD_SCAN_FALLBACK_EN
    // Sweep-mode flag. It is set on try exhaustion and cleared on each new request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan <= 1'b0;
        end else begin
            scan <= scan_n;
        end
    end
`endif

endmodule

// File: tb/tb_food_spawner.sv
`timescale 1ns/1ps
// Bench for food_spawner: a PRNG feeder, an occupancy responder and a result scoreboard.
module tb_food_spawner;

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam int GW = 4;
    localparam int GH = 4;
    localparam int MT = 2;
`else
    localparam int GW = 40;
    localparam int GH = 30;
    localparam int MT = 4;
`endif
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          place_req = 1'b0;
    logic [CW-1:0] rnd = '0;
    logic          rnd_step;
    logic          occ_req;
    logic [CW-1:0] occ_x, occ_y;
    logic          occ_ack = 1'b0;
    logic          occ_hit = 1'b0;
    logic [CW-1:0] food_x, food_y;
    logic          done, fail, busy;
    logic [2:0]    state_dbg;

    food_spawner #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .place_req(place_req), .rnd(rnd), .rnd_step(rnd_step),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack),
        .occ_hit(occ_hit), .food_x(food_x), .food_y(food_y), .done(done),
        .fail(fail), .busy(busy), .state_dbg(state_dbg)
    );

    int checks_total = 0;
    int checks_passed = 0;
    int cyc = 0;
    int req_cyc = 0;
    int last_end_cyc = 0;
    int rnd_steps = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [CW-1:0]   q_x, q_y;
    logic [CW-1:0]   rnd_q[$];
    logic [2*CW-1:0] qlog[$];
    logic [2*CW-1:0] qexp[$];
    logic [2*CW:0]   exp_q[$];
    logic [2*CW:0]   exp_e;
    bit              occ_map [64][64];

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("FAIL %s: actual %0d required %0d", name, actual, expected);
    endtask

    // PRNG model: the word on rnd is consumed at each edge where rnd_step is high.
    always @(posedge clk) begin
        if (rnd_step) begin
            rnd_steps++;
            #1;
            if (rnd_q.size() > 0) void'(rnd_q.pop_front());
            rnd = (rnd_q.size() > 0) ? rnd_q[0] : '0;
        end
    end

    // Occupancy responder: acks after ack_delay cycles and checks that the query address holds steady.
    always @(negedge clk) begin
        if (occ_req) begin
            if (occ_ack) check("occ_req_after_ack", occ_req, 0);
            if (wait_cnt == 0) begin
                q_x = occ_x;
                q_y = occ_y;
            end else begin
                check("occ_x_stable", occ_x, q_x);
                check("occ_y_stable", occ_y, q_y);
            end
            if (wait_cnt == ack_delay) begin
                occ_ack = 1'b1;
                occ_hit = occ_map[occ_x][occ_y];
                qlog.push_back({occ_x, occ_y});
            end else begin
                occ_ack = 1'b0;
                occ_hit = 1'b0;
            end
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            occ_ack  = 1'b0;
            occ_hit  = 1'b0;
        end
    end

    // Scoreboard monitor: every done/fail pulse is matched against the expected queue.
    always @(negedge clk) begin
        if (done || fail) begin
            last_end_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_result: actual done=%0b fail=%0b food=(%0d,%0d) required no pulse",
                         done, fail, food_x, food_y);
            end else begin
                exp_e = exp_q.pop_front();
                check("result_kind", {done, fail}, exp_e[2*CW] ? 1 : 2);
                check("food_x", food_x, exp_e[2*CW-1:CW]);
                check("food_y", food_y, exp_e[CW-1:0]);
            end
        end
    end

    task automatic setup(input int delay, input bit fill);
        ack_delay = delay;
        foreach (occ_map[i, j]) occ_map[i][j] = fill;
        qlog.delete();
        qexp.delete();
        rnd_q.delete();
        rnd_steps = 0;
    endtask

    task automatic push_rnd(input int v);
        rnd_q.push_back(CW'(v));
        rnd = rnd_q[0];
    endtask

    task automatic exp_query(input int x, input int y);
        qexp.push_back({CW'(x), CW'(y)});
    endtask

    task automatic exp_result(input bit is_fail, input int x, input int y);
        exp_q.push_back({is_fail, CW'(x), CW'(y)});
    endtask

    task automatic start_op();
        @(posedge clk);
        #1 place_req = 1'b1;
        req_cyc = cyc;
        @(posedge clk);
        #1 place_req = 1'b0;
        check("busy_on_accept", busy, 1);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(done || fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("end_within_budget", int'(done || fail), 1);
        @(negedge clk);
        check("busy_dropped", busy, 0);
    endtask

    task automatic check_queries(input string name);
        check({name, "_query_count"}, qlog.size(), qexp.size());
        for (int i = 0; i < qlog.size() && i < qexp.size(); i++)
            check({name, "_query_cell"}, qlog[i], qexp[i]);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_occ_req", occ_req, 0);
        check("rst_rnd_step", rnd_step, 0);
        check("rst_food_x", food_x, 0);
        check("rst_food_y", food_y, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clk) rst = 1'b1;

`ifdef FOOD_SCAN_FALLBACK_EN
        // Happy path in the small grid.
        setup(0, 1'b0);
        push_rnd(1); push_rnd(2);
        exp_query(1, 2);
        exp_result(1'b0, 1, 2);
        start_op();
        wait_end(50);
        check("happy_latency", last_end_cyc - req_cyc, 5);
        check("happy_rnd_steps", rnd_steps, 2);
        check_queries("happy");

        // Only (3,1) free: two random rejects, then a sweep from (0,0).
        setup(0, 1'b1);
        occ_map[3][1] = 1'b0;
        push_rnd(0); push_rnd(0); push_rnd(1); push_rnd(0);
        exp_query(0, 0); exp_query(1, 0);
        for (int i = 0; i < 8; i++) exp_query(i % 4, i / 4);
        exp_result(1'b0, 3, 1);
        start_op();
        wait_end(400);
        check("sweep_rnd_steps", rnd_steps, 4);
        check_queries("sweep");

        // All occupied: range reject, occupied reject, full sweep, then fail with food unchanged.
        setup(1, 1'b1);
        push_rnd(5); push_rnd(5); push_rnd(0); push_rnd(0);
        exp_query(0, 0);
        for (int i = 0; i < 16; i++) exp_query(i % 4, i / 4);
        exp_result(1'b1, 3, 1);
        start_op();
        wait_end(400);
        check("sweep_fail_rnd_steps", rnd_steps, 4);
        check_queries("sweep_fail");
`else
        // Happy path: minimum latency, two PRNG steps.
        setup(0, 1'b0);
        push_rnd(5); push_rnd(7);
        exp_query(5, 7);
        exp_result(1'b0, 5, 7);
        start_op();
        wait_end(50);
        check("happy_latency", last_end_cyc - req_cyc, 5);
        check("happy_rnd_steps", rnd_steps, 2);
        check_queries("happy");

        // Range rejects: no query for (45,3) or (12,31).
        setup(0, 1'b0);
        push_rnd(45); push_rnd(3); push_rnd(12); push_rnd(31); push_rnd(10); push_rnd(4);
        exp_query(10, 4);
        exp_result(1'b0, 10, 4);
        start_op();
        wait_end(100);
        check("range_rnd_steps", rnd_steps, 6);
        check_queries("range");

        // Occupied reject with a delayed ack.
        setup(3, 1'b0);
        occ_map[2][2] = 1'b1;
        push_rnd(2); push_rnd(2); push_rnd(9); push_rnd(9);
        exp_query(2, 2); exp_query(9, 9);
        exp_result(1'b0, 9, 9);
        start_op();
        wait_end(100);
        check("occupied_rnd_steps", rnd_steps, 4);
        check_queries("occupied");

        // Edge of the grid: 40 and 30 are rejected, (39,29) is accepted.
        setup(0, 1'b0);
        push_rnd(40); push_rnd(0); push_rnd(0); push_rnd(30); push_rnd(39); push_rnd(29);
        exp_query(39, 29);
        exp_result(1'b0, 39, 29);
        start_op();
        wait_end(100);
        check_queries("edge");

        // Exhaustion: four occupied candidates give fail, and food keeps (39,29).
        setup(0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            occ_map[i][i] = 1'b1;
            push_rnd(i); push_rnd(i);
            exp_query(i, i);
        end
        exp_result(1'b1, 39, 29);
        start_op();
        wait_end(200);
        check("exhaust_rnd_steps", rnd_steps, 8);
        check_queries("exhaust");

        // Requests while busy and in the done cycle are ignored.
        setup(0, 1'b0);
        push_rnd(6); push_rnd(6);
        exp_query(6, 6);
        exp_result(1'b0, 6, 6);
        start_op();
        place_req = 1'b1;
        @(posedge clk);
        #1 place_req = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!done && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("ignore_done_seen", done, 1);
        place_req = 1'b1;
        @(posedge clk);
        #1 place_req = 1'b0;
        check("req_in_done_ignored", busy, 0);
        repeat (3) @(negedge clk);
        check("ignore_rnd_steps", rnd_steps, 2);
        check_queries("ignore");
`endif

        // Reset while a query is outstanding, then a normal request afterwards.
        setup(20, 1'b0);
        push_rnd(1); push_rnd(1);
        start_op();
        begin
            int n = 0;
            while (!occ_req && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("abort_occ_req_up", occ_req, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_occ_req", occ_req, 0);
        check("abort_busy", busy, 0);
        check("abort_food_x", food_x, 0);
        check("abort_food_y", food_y, 0);
        check("abort_done", done, 0);
        check("abort_fail", fail, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        setup(1, 1'b0);
        push_rnd(3); push_rnd(2);
        exp_query(3, 2);
        exp_result(1'b0, 3, 2);
        start_op();
        wait_end(50);
        check("after_reset_latency", last_end_cyc - req_cyc, 6);
        check_queries("after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
- Consumer end of the 6-bit LFSR random source. It turns raw random words into a legal, unoccupied food cell on the snake playfield.
- Sits between the game-control FSM, the PRNG and the snake-body occupancy lookup.
- On request, it draws X then Y samples and rejects out-of-range or occupied cells. It retries up to a limit, then reports the placement.

Parameters:
- GRID_W, 40, playfield width in cells; valid X is 0..GRID_W-1.
- GRID_H, 30, playfield height in cells; valid Y is 0..GRID_H-1.
- COORD_W, 6, width of random word and coordinates; GRID_W and GRID_H must be <= 2^COORD_W.
- MAX_TRIES, 16, random attempts before fallback or fail; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- place_req  in  1  one-cycle request for a new food cell; ignored while busy=1.
- rnd  in  COORD_W  random word from PRNG; sampled in the cycle rnd_step=1.
- rnd_step  out  1  advance/consume strobe to PRNG.
- occ_req  out  1  occupancy query valid; held until occ_ack.
- occ_x  out  COORD_W  queried X; stable while occ_req=1.
- occ_y  out  COORD_W  queried Y; stable while occ_req=1.
- occ_ack  in  1  query answered; may arrive in the same cycle occ_req rises or any later cycle.
- occ_hit  in  1  cell occupied; valid only with occ_ack.
- food_x  out  COORD_W  placed food X; registered.
- food_y  out  COORD_W  placed food Y; registered.
- done  out  1  one-cycle pulse; food_x/food_y updated in the same cycle.
- fail  out  1  one-cycle pulse; no free cell found; food_x/food_y unchanged.
- busy  out  1  high from the cycle after an accepted place_req through the done/fail cycle.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including food_x, food_y, busy, done, fail, occ_req and rnd_step. Try counter is 0.
- Reset mid-operation aborts immediately. No done/fail is issued, and any outstanding occ_req is dropped.
- States: IDLE, GET_X, GET_Y, CHECK, QUERY, SCAN, DONE, FAIL.
- IDLE: place_req=1 -> GET_X, tries cleared to 0.
- GET_X: rnd_step=1; latch cand_x=rnd -> GET_Y.
- GET_Y: rnd_step=1; latch cand_y=rnd -> CHECK.
- CHECK (no PRNG step):
  - If cand_x>=GRID_W or cand_y>=GRID_H, count a try, then go to retry.
  - Otherwise -> QUERY.
- QUERY:
  - occ_req=1, occ_x=cand_x, occ_y=cand_y.
  - On occ_ack with occ_hit=0 -> DONE.
  - On occ_ack with occ_hit=1, count a try, then go to retry.
- Retry: if tries==MAX_TRIES -> fallback (see Optional Feature), else -> GET_X.
- Try counter increments by 1 per rejected candidate; it saturates and never wraps.
- DONE: food_x/food_y <= cand, done=1 for one cycle -> IDLE.
- FAIL: fail=1 for one cycle -> IDLE.
- occ_req deasserts the cycle after occ_ack.
- Minimum latency, first candidate accepted with occ_ack in the first QUERY cycle: place_req at cycle 0 -> done at cycle 5.
- place_req asserted in the same cycle as done/fail is ignored. The requester must re-issue it.

Optional Feature:
- Macro FOOD_SCAN_FALLBACK_EN.
- Defined: on try exhaustion -> SCAN.
  - Linear sweep from (0,0): X increments first, Y increments when X wraps at GRID_W-1.
  - Each cell is queried via the QUERY handshake.
  - First occ_hit=0 -> DONE with that cell.
  - After cell (GRID_W-1, GRID_H-1) is hit -> FAIL.
  - No rnd_step during SCAN.
- Undefined: try exhaustion -> FAIL directly; SCAN state is absent.

Test Plan:
- Happy path:
  - Stimulus: rnd sequence 5,7; occ_ack same cycle as occ_req with occ_hit=0.
  - Response: done at cycle 5 after place_req; food=(5,7); exactly 2 rnd_step pulses.
- Range reject:
  - Stimulus: rnd sequence 45,3,12,31,10,4 (X 45>=40, then Y 31>=30).
  - Response: no occ_req for the first two candidates; done with food=(10,4); 6 rnd_step pulses.
- Occupied reject:
  - Stimulus: occ_hit=1 for candidate (2,2); occ_ack delayed 3 cycles; next candidate (9,9) free.
  - Response: occ_x/occ_y stable for 3 cycles; done with (9,9).
- Exhaustion, macro undefined:
  - Stimulus: MAX_TRIES=4; all candidates occupied.
  - Response: fail pulse after 4th rejection; food_x/food_y keep their previous value; busy then drops.
- Exhaustion, macro defined:
  - Stimulus: MAX_TRIES=2, GRID 4x4; only cell (3,1) free.
  - Response: sweep queries (0,0)..(3,1) in order; done with (3,1).
  - Variant with all cells occupied -> fail after (3,3).
- Reset mid-QUERY:
  - Stimulus: drop rst to 0 while occ_req=1.
  - Response: occ_req, busy and food outputs go to 0 asynchronously; no done/fail pulse.
  - Follow-up: a new place_req after release completes normally.
